shift_add_mul: RTL and testbench



---
 rtl/mul_pkg.sv | 15 +
 rtl/add.sv | 23 ++
 rtl/shift_add_mul.sv | 116 +++++++++++
 tb/tb_shift_add_mul.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types and helpers for the iterative shift-and-add multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  // Counter must reach WIDTH without wrapping, hence WIDTH+1 states.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/add.sv
// Ripple-carry adder: S/Cout = A + B + Cin.
module add #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  logic [WIDTH:0] carry_s;

  assign carry_s[0] = Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign S[i]         = A[i] ^ B[i] ^ carry_s[i];
    assign carry_s[i+1] = (A[i] & B[i]) | (carry_s[i] & (A[i] ^ B[i]));
  end

  assign Cout = carry_s[WIDTH];

endmodule

// File: rtl/shift_add_mul.sv
// Iterative unsigned multiplier: one partial-product add per cycle through
// a single ripple-carry adder, with valid/ready handshakes on both sides.
module shift_add_mul
  import mul_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] P,
  output logic               busy
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mul_state_e         state_r, next_state_s;
  logic [WIDTH-1:0]   mcand_r, hi_r, lo_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [2*WIDTH-1:0] p_r;
  logic               in_ready_r, out_valid_r, busy_r;

  logic [WIDTH-1:0]   gated_s, sum_s;
  logic               cout_s;
  logic [2*WIDTH-1:0] shifted_s;

  assign gated_s = lo_r[0] ? mcand_r : {WIDTH{1'b0}};

  add #(.WIDTH(WIDTH)) u_add (
    .A    (hi_r),
    .B    (gated_s),
    .Cin  (1'b0),
    .S    (sum_s),
    .Cout (cout_s)
  );

  // Carry-out re-enters at the top so the product stays exact.
  assign shifted_s = {cout_s, sum_s, lo_r[WIDTH-1:1]};

  // Next-state decode; in_ready is implied by being in IDLE.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) next_state_s = BUSY;
        else          next_state_s = IDLE;
      end
      BUSY: begin
        if (cnt_r == LAST_CNT) next_state_s = DONE;
        else                   next_state_s = BUSY;
      end
      DONE: begin
        if (out_ready) next_state_s = IDLE;
        else           next_state_s = DONE;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State register with handshake flags registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      in_ready_r  <= (next_state_s == IDLE);
      out_valid_r <= (next_state_s == DONE);
      busy_r      <= (next_state_s == BUSY);
    end
  end

  // Operand capture, shifting accumulator, iteration counter, product latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_r <= {WIDTH{1'b0}};
      hi_r    <= {WIDTH{1'b0}};
      lo_r    <= {WIDTH{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      p_r     <= {(2*WIDTH){1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            mcand_r <= A;
            lo_r    <= B;
            hi_r    <= {WIDTH{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
          end
        end
        BUSY: begin
          {hi_r, lo_r} <= shifted_s;
          cnt_r        <= cnt_r + CNT_ONE;
          if (cnt_r == LAST_CNT) p_r <= shifted_s;
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign P         = p_r;

endmodule

// File: tb/tb_shift_add_mul.sv
// Self-checking bench: directed vector table, corner sequences, and
// back-to-back streams scored against plain A*B arithmetic.
module tb_shift_add_mul;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       iv4, ir4, ov4, or4, busy4;
  logic [3:0] a4, b4;
  logic [7:0] p4;
  logic       iv8, ir8, ov8, or8, busy8;
  logic [7:0] a8, b8;
  logic [15:0] p8;

  shift_add_mul #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .A(a4), .B(b4),
    .out_valid(ov4), .out_ready(or4), .P(p4), .busy(busy4));

  shift_add_mul #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8),
    .out_valid(ov8), .out_ready(or8), .P(p8), .busy(busy8));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Scoreboards: accepted operand pairs queue their true product.
  int q4[$];
  int q8[$];
  int last4 = -1, last8 = -1;
  bit bb4 = 1'b0, bb8 = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      q4.delete();
    end else begin
      if (iv4 && ir4) q4.push_back(int'(a4) * int'(b4));
      if (ov4 && or4) begin
        if (q4.size() == 0) chk("sb4_unexpected_product", 64'd1, 64'd0);
        else chk("sb4_p", p4, q4.pop_front());
        if (bb4 && last4 >= 0) chk("spacing4", cyc - last4, 64'd6);
        last4 = cyc;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      q8.delete();
    end else begin
      if (iv8 && ir8) q8.push_back(int'(a8) * int'(b8));
      if (ov8 && or8) begin
        if (q8.size() == 0) chk("sb8_unexpected_product", 64'd1, 64'd0);
        else chk("sb8_p", p8, q8.pop_front());
        if (bb8 && last8 >= 0) chk("spacing8", cyc - last8, 64'd10);
        last8 = cyc;
      end
    end
  end

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] p;
    int         hold;
  } vec_t;

  vec_t vecs[5];

  // One directed WIDTH=4 transaction; hold>0 keeps out_ready low that long.
  task automatic run_vec(input vec_t v);
    int lat;
    a4 = v.a; b4 = v.b; iv4 = 1'b1; or4 = (v.hold == 0);
    chk("vec_in_ready_before", ir4, 64'd1);
    tick;
    iv4 = 1'b0;
    chk("vec_in_ready_drop", ir4, 64'd0);
    chk("vec_busy", busy4, 64'd1);
    lat = 1;
    while (!ov4 && lat < 30) begin
      tick;
      lat++;
    end
    chk("vec_latency", lat, 64'd5);
    chk("vec_p", p4, v.p);
    if (v.hold > 0) begin
      for (int i = 0; i < v.hold; i++) begin
        iv4 = (i == 3); a4 = 4'd1; b4 = 4'd1;
        tick;
        chk("hold_out_valid", ov4, 64'd1);
        chk("hold_p", p4, v.p);
        chk("hold_in_ready", ir4, 64'd0);
      end
      iv4 = 1'b0;
      or4 = 1'b1;
    end
    tick;
    chk("vec_idle_in_ready", ir4, 64'd1);
    chk("vec_idle_out_valid", ov4, 64'd0);
  endtask

  initial begin
    int w;
    logic [15:0] pair;

    vecs[0] = '{a: 4'd3, b: 4'd5, p: 8'h0F, hold: 0};
    vecs[1] = '{a: 4'hF, b: 4'hF, p: 8'hE1, hold: 0};
    vecs[2] = '{a: 4'h9, b: 4'h0, p: 8'h00, hold: 0};
    vecs[3] = '{a: 4'h0, b: 4'hA, p: 8'h00, hold: 0};
    vecs[4] = '{a: 4'd7, b: 4'd6, p: 8'h2A, hold: 10};

    rst = 1'b1;
    iv4 = 1'b0; or4 = 1'b0; a4 = 4'd0; b4 = 4'd0;
    iv8 = 1'b0; or8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
    repeat (3) tick;
    rst = 1'b0;
    chk("rst_in_ready", ir4, 64'd1);
    chk("rst_out_valid", ov4, 64'd0);
    chk("rst_busy", busy4, 64'd0);
    chk("rst_p", p4, 64'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset in the second BUSY cycle discards the in-flight product.
    a4 = 4'hF; b4 = 4'hE; iv4 = 1'b1; or4 = 1'b1;
    tick;
    iv4 = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("midrst_in_ready", ir4, 64'd1);
    chk("midrst_out_valid", ov4, 64'd0);
    chk("midrst_busy", busy4, 64'd0);
    chk("midrst_p", p4, 64'd0);
    run_vec('{a: 4'd2, b: 4'd3, p: 8'h06, hold: 0});

    // Exhaustive WIDTH=4, in_valid held high across transactions.
    bb4 = 1'b1; last4 = -1; or4 = 1'b1; iv4 = 1'b1;
    for (int k = 0; k < 256; k++) begin
      pair = 16'(k);
      a4 = pair[7:4]; b4 = pair[3:0];
      w = 0;
      while (!ir4 && w < 20) begin
        tick;
        w++;
      end
      if (w >= 20) chk("accept_timeout4", 64'd0, 64'd1);
      tick;
    end
    iv4 = 1'b0;
    repeat (10) tick;
    chk("sb4_drained", q4.size(), 64'd0);
    bb4 = 1'b0;

    // Random WIDTH=8 stream, with extreme operands first.
    bb8 = 1'b1; last8 = -1; or8 = 1'b1; iv8 = 1'b1;
    for (int k = 0; k < 60; k++) begin
      if (k == 0)      begin a8 = 8'hFF; b8 = 8'hFF; end
      else if (k == 1) begin a8 = 8'h00; b8 = 8'hC3; end
      else begin
        a8 = 8'($urandom_range(0, 255));
        b8 = 8'($urandom_range(0, 255));
      end
      w = 0;
      while (!ir8 && w < 30) begin
        tick;
        w++;
      end
      if (w >= 30) chk("accept_timeout8", 64'd0, 64'd1);
      tick;
    end
    iv8 = 1'b0;
    repeat (14) tick;
    chk("sb8_drained", q8.size(), 64'd0);
    bb8 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
